// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader: state encoding, word geometry and
// default sizing of the program memory.
package program_loader_pkg;

    localparam int WIDTH_DEF      = 32;
    localparam int ADD_WIDTH_DEF  = 8;
    localparam int DEPTH_DEF      = 256;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/program_loader_byte_to_word.sv
// Little-endian byte assembler: four accepted bytes form one instruction word,
// the first byte landing in [7:0].
module byte_to_word
    import program_loader_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             byte_en,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] word,
    output logic             word_valid
);

    logic [WIDTH-1:0] shift_r;
    logic [1:0]       cnt_r;

    // The word is offered combinationally so the FSM can write the cycle after the last byte.
    assign word       = {byte_in, shift_r[WIDTH-1:8]};
    assign word_valid = byte_en && (cnt_r == 2'(BYTES_PER_WORD - 1));

    // Shift register and byte counter; clear discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {WIDTH{1'b0}};
            cnt_r   <= 2'd0;
        end else if (clear) begin
            shift_r <= {WIDTH{1'b0}};
            cnt_r   <= 2'd0;
        end else if (byte_en) begin
            shift_r <= word;
            cnt_r   <= cnt_r + 2'd1;
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams bytes from a serial receiver into program memory one word at a time,
// holding the CPU in reset while the image is being written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ADD_WIDTH = ADD_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADD_WIDTH:0]   num_words,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 mem_wen,
    output logic [ADD_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done
);

    localparam int               CNT_W     = ADD_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_LIM = CNT_W'(DEPTH);

    logic [1:0]           state_r, state_nxt_s;
    logic [CNT_W-1:0]     count_r, words_r, words_inc_s, num_sat_s;
    logic                 in_ready_r, mem_wen_r, busy_r, done_r;
    logic [ADD_WIDTH-1:0] mem_addr_r;
    logic [WIDTH-1:0]     mem_wdata_r, word_s;
    logic                 accept_s, byte_en_s, clear_s, word_valid_s;

    assign accept_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign byte_en_s   = in_valid && in_ready_r && !abort;
    assign clear_s     = accept_s || abort;
    assign num_sat_s   = (num_words > DEPTH_LIM) ? DEPTH_LIM : num_words;
    assign words_inc_s = words_r + {{ADD_WIDTH{1'b0}}, 1'b1};

    byte_to_word #(.WIDTH(WIDTH)) u_byte_to_word (
        .clk        (clk),
        .rst_n      (rst),
        .clear      (clear_s),
        .byte_en    (byte_en_s),
        .byte_in    (in_data),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Next-state logic; abort outranks everything while a load is active.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s = (num_sat_s == {CNT_W{1'b0}}) ? ST_DONE : ST_COLLECT;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_COLLECT: begin
                if (abort)             state_nxt_s = ST_IDLE;
                else if (word_valid_s) state_nxt_s = ST_WRITE;
                else                   state_nxt_s = ST_COLLECT;
            end
            ST_WRITE: begin
                if (abort)                       state_nxt_s = ST_IDLE;
                else if (words_inc_s == count_r) state_nxt_s = ST_DONE;
                else                             state_nxt_s = ST_COLLECT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            count_r     <= {CNT_W{1'b0}};
            words_r     <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b0;
            mem_wen_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mem_addr_r  <= {ADD_WIDTH{1'b0}};
            mem_wdata_r <= {WIDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == ST_COLLECT);
            mem_wen_r  <= (state_nxt_s == ST_WRITE);
            busy_r     <= (state_nxt_s == ST_COLLECT) || (state_nxt_s == ST_WRITE);
            done_r     <= (state_nxt_s == ST_DONE);
            if (accept_s) begin
                count_r <= num_sat_s;
                words_r <= {CNT_W{1'b0}};
            end else if (state_r == ST_WRITE) begin
                count_r <= count_r;
                words_r <= words_inc_s;
            end else begin
                count_r <= count_r;
                words_r <= words_r;
            end
            // words_r never exceeds DEPTH-1 here, so the truncated index cannot wrap.
            if ((state_r == ST_COLLECT) && (state_nxt_s == ST_WRITE)) begin
                mem_addr_r  <= words_r[ADD_WIDTH-1:0];
                mem_wdata_r <= word_s;
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_wen   = mem_wen_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign cpu_hold  = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: byte streams with hand-computed words,
// zero/oversize counts, abort and mid-load reset.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, in_valid;
    logic [8:0]  num_words;
    logic [7:0]  in_data;
    logic        in_ready, mem_wen, cpu_hold, busy, done;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    int err_cnt = 0;
    int chk_cnt = 0;
    int to_cnt  = 0;
    bit hold_seen = 1'b0;
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    program_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_words(num_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Memory-side monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_wen === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (cpu_hold === 1'b1) hold_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [8:0] n);
        start = 1'b1;
        num_words = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int c = 0; c < 50 && !ok; c++) begin
            ok = in_ready;
            tick();
        end
        if (!ok) to_cnt++;
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 50 && done !== 1'b1; c++) tick();
        chk(tag, done, 1'b1);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] t3_bytes [4];
        logic [7:0] iv;
        bit v, xfer;
        int k, bad;

        rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        num_words = 9'd0; in_data = 8'd0;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b1;
        tick();

        // Zero-length load goes straight to DONE.
        clear_log();
        hold_seen = 1'b0;
        do_start(9'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        repeat (3) tick();
        chk("zero_writes", wr_addr.size(), 0);
        chk("zero_hold", hold_seen, 0);

        // Two words streamed back-to-back.
        clear_log();
        do_start(9'd2);
        chk("t1_busy", busy, 1);
        chk("t1_hold", cpu_hold, 1);
        chk("t1_ready", in_ready, 1);
        chk("t1_done_clr", done, 0);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("t1_wen1", mem_wen, 1);
        chk("t1_ready_wr", in_ready, 0);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        in_valid = 1'b0;
        chk("t1_wen2", mem_wen, 1);
        chk("t1_addr2", mem_addr, 1);
        chk("t1_data2", mem_wdata, 32'h0010_0093);
        tick();
        chk("t1_done", done, 1);
        chk("t1_hold_off", cpu_hold, 0);
        chk("t1_busy_off", busy, 0);
        chk("t1_nwr", wr_addr.size(), 2);
        chk("t1_a0", wr_addr[0], 0);
        chk("t1_d0", wr_data[0], 32'h0000_0013);
        chk("t1_a1", wr_addr[1], 1);
        chk("t1_d1", wr_data[1], 32'h0010_0093);

        // One word with in_valid toggling; start held high while busy must be ignored.
        clear_log();
        t3_bytes[0] = 8'hAA; t3_bytes[1] = 8'hBB; t3_bytes[2] = 8'hCC; t3_bytes[3] = 8'hDD;
        do_start(9'd1);
        start = 1'b1;
        num_words = 9'd0;
        k = 0;
        v = 1'b0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            v = ~v;
            in_valid = v;
            in_data = t3_bytes[k];
            xfer = v && in_ready;
            tick();
            if (xfer) k++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk("t3_bytes_taken", k, 4);
        chk("t3_wen", mem_wen, 1);
        chk("t3_nwr_early", wr_addr.size(), 0);
        wait_done("t3_done");
        chk("t3_nwr", wr_addr.size(), 1);
        chk("t3_a0", wr_addr[0], 0);
        chk("t3_d0", wr_data[0], 32'hDDCC_BBAA);

        // Abort after six bytes of a three-word load.
        clear_log();
        do_start(9'd3);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_ready", in_ready, 0);
        repeat (2) tick();
        chk("t4_nwr", wr_addr.size(), 1);
        chk("t4_a0", wr_addr[0], 0);
        chk("t4_d0", wr_data[0], 32'h0403_0201);
        do_start(9'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        in_valid = 1'b0;
        wait_done("t4_re_done");
        chk("t4_re_nwr", wr_addr.size(), 2);
        chk("t4_re_a", wr_addr[1], 0);
        chk("t4_re_d", wr_data[1], 32'h4433_2211);

        // Oversized count saturates to the full memory.
        clear_log();
        do_start(9'd300);
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            send_byte(iv); send_byte(8'hA5); send_byte(8'h5A); send_byte(~iv);
        end
        in_valid = 1'b0;
        wait_done("t5_done");
        chk("t5_nwr", wr_addr.size(), 256);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            iv = 8'(i);
            if (wr_addr[i] !== iv || wr_data[i] !== {~iv, 8'h5A, 8'hA5, iv}) bad++;
        end
        chk("t5_seq_bad", bad, 0);
        chk("t5_ready_off", in_ready, 0);

        // Reset in the middle of a word.
        clear_log();
        do_start(9'd1);
        send_byte(8'h01); send_byte(8'h02);
        rst = 1'b0;
        #1;
        chk("t6_ready", in_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_hold", cpu_hold, 0);
        chk("t6_done", done, 0);
        chk("t6_wen", mem_wen, 0);
        chk("t6_addr", mem_addr, 0);
        chk("t6_wdata", mem_wdata, 0);
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("t6_nwr_rst", wr_addr.size(), 0);
        do_start(9'd1);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        in_valid = 1'b0;
        wait_done("t6_re_done");
        chk("t6_re_nwr", wr_addr.size(), 1);
        chk("t6_re_a", wr_addr[0], 0);
        chk("t6_re_d", wr_data[0], 32'hDEAD_BEEF);

        chk("handshake_timeouts", to_cnt, 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
